// File: rtl/dtw_core_feeder.sv
// Sequences one DTW core run: clear, stream squiggle/reference samples from
// two synchronous-read memories, wait for done plus settle, return the result.
module dtw_core_feeder #(
  parameter int unsigned width         = 16,
  parameter int unsigned SQG_SIZE      = 10,
  parameter int unsigned ADDR_W        = 16,
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned TIMEOUT       = 65535
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] cfg_sqg_base,
  input  logic [ADDR_W-1:0] cfg_ref_base,
  input  logic [31:0]       cfg_ref_len,
  output logic              busy,
  output logic [ADDR_W-1:0] sqg_addr,
  input  logic [width-1:0]  sqg_rdata,
  output logic [ADDR_W-1:0] ref_addr,
  input  logic [width-1:0]  ref_rdata,
  output logic              core_rst,
  output logic              core_running,
  output logic [width-1:0]  core_squiggle,
  output logic [width-1:0]  core_rword,
  output logic [31:0]       core_ref_len,
  input  logic [width-1:0]  core_minval,
  input  logic [31:0]       core_position,
  input  logic              core_done,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [width-1:0]  res_minval,
  output logic [31:0]       res_position,
  output logic              res_error
);

  localparam int unsigned CNT_W    = 32;
  localparam int unsigned SETTLE_W = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] SQG_LEN  = CNT_W'(SQG_SIZE);
  localparam logic [CNT_W-1:0] RUN_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, CLEAR, STREAM, SETTLE, RESULT} state_t;

  state_t              state;
  state_t              state_nxt;
  logic [ADDR_W-1:0]   sqg_base;
  logic [ADDR_W-1:0]   ref_base;
  // cyc is both the stream read index and the running-cycle (timeout) counter
  logic [CNT_W-1:0]    cyc;
  logic [CNT_W-1:0]    cyc_nxt;
  logic [SETTLE_W-1:0] settle_cnt;
  logic                sqg_rd;
  logic                ref_rd;
  logic                sqg_rd_q;
  logic                ref_rd_q;
  logic                timeout;
  logic                settle_done;

  assign cyc_nxt     = cyc + CNT_W'(1);
  assign sqg_rd      = (state == STREAM) && (cyc < SQG_LEN);
  assign ref_rd      = (state == STREAM) && (cyc < core_ref_len);
  assign timeout     = (cyc >= RUN_LAST);
  assign settle_done = (settle_cnt == SETTLE_W'(1));

  // Samples only reach the core when a read was issued on the previous cycle
  assign core_squiggle = sqg_rd_q ? sqg_rdata : '0;
  assign core_rword    = ref_rd_q ? ref_rdata : '0;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = (cfg_ref_len == 32'd0) ? RESULT : CLEAR;
      CLEAR:   state_nxt = STREAM;
      STREAM: begin
        if (core_done)    state_nxt = SETTLE;
        else if (timeout) state_nxt = RESULT;
      end
      SETTLE:  if (settle_done) state_nxt = RESULT;
      RESULT:  if (res_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    busy         = 1'b0;
    core_running = 1'b0;
    res_valid    = 1'b0;
    core_rst     = rst;
    case (state)
      IDLE:    ;
      CLEAR:   begin busy = 1'b1; core_rst = 1'b1; end
      STREAM:  begin busy = 1'b1; core_running = 1'b1; end
      SETTLE:  begin busy = 1'b1; core_running = 1'b1; end
      RESULT:  begin busy = 1'b1; res_valid = 1'b1; end
      default: ;
    endcase
  end

  // Config latch, read addressing, counters and result capture
  always_ff @(posedge clk) begin
    if (rst) begin
      sqg_base     <= '0;
      ref_base     <= '0;
      core_ref_len <= '0;
      sqg_addr     <= '0;
      ref_addr     <= '0;
      cyc          <= '0;
      settle_cnt   <= '0;
      sqg_rd_q     <= 1'b0;
      ref_rd_q     <= 1'b0;
      res_minval   <= '1;
      res_position <= '0;
      res_error    <= 1'b0;
    end else begin
      sqg_rd_q <= sqg_rd;
      ref_rd_q <= ref_rd;
      case (state)
        IDLE: begin
          if (start) begin
            sqg_base     <= cfg_sqg_base;
            ref_base     <= cfg_ref_base;
            core_ref_len <= cfg_ref_len;
            if (cfg_ref_len == 32'd0) begin
              res_minval   <= '1;
              res_position <= '0;
              res_error    <= 1'b1;
            end
          end
        end
        CLEAR: begin
          cyc      <= '0;
          sqg_addr <= sqg_base;
          ref_addr <= ref_base;
        end
        STREAM: begin
          cyc <= cyc_nxt;
          // Addresses are registered one cycle ahead of the read they serve
          if (cyc_nxt < SQG_LEN)      sqg_addr <= sqg_base + ADDR_W'(cyc_nxt);
          if (cyc_nxt < core_ref_len) ref_addr <= ref_base + ADDR_W'(cyc_nxt);
          if (core_done) begin
            settle_cnt <= SETTLE_W'(SETTLE_CYCLES);
          end else if (timeout) begin
            res_minval   <= '1;
            res_position <= '0;
            res_error    <= 1'b1;
          end
        end
        SETTLE: begin
          cyc        <= cyc_nxt;
          settle_cnt <= settle_cnt - SETTLE_W'(1);
          if (settle_done) begin
            res_minval   <= core_minval;
            res_position <= core_position;
            res_error    <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
